// File: rtl/window3x3_linebuf_rgb888.sv
// Streaming 3x3 window generator for RGB888 raster video, backed by two line buffers.
// Define WIN3_REPLICATE_EDGE_EN for edge-replicate padding; otherwise out-of-image taps are zero.
module window3x3_linebuf_rgb888 #(
  parameter int unsigned IMG_W = 320,
  parameter int unsigned IMG_H = 240
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [23:0]  pixel_in,
  output logic         out_valid,
  output logic [215:0] window,
  output logic [16:0]  out_addr,
  output logic         frame_done
);
  localparam int unsigned PW = 24;
  localparam int unsigned XW = 9;
  localparam int unsigned YW = 8;
  localparam int unsigned AW = $clog2(IMG_W);

  typedef enum logic [1:0] {IDLE, RUN, EOL, FLUSH} state_t;
  state_t state, state_nxt;

  logic [PW-1:0] lb0 [IMG_W];
  logic [PW-1:0] lb1 [IMG_W];

  logic [XW-1:0] in_x, x_nxt, cx;
  logic [YW-1:0] in_y, y_nxt, cy;
  logic [AW-1:0] rd_idx;
  logic          accept, shift, emit, last_win, lb_wr;
  logic [PW-1:0] col_top, col_mid, col_bot;

  // taps[row][col]: row 0 is the oldest line, col 2 the newest column
  logic [0:2][0:2][PW-1:0] taps, taps_nxt, win_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, column sources and the centre coordinate of any window completed this cycle
  always_comb begin
    state_nxt = state;
    x_nxt     = in_x;
    y_nxt     = in_y;
    shift     = 1'b0;
    emit      = 1'b0;
    last_win  = 1'b0;
    col_top   = '0;
    col_mid   = '0;
    col_bot   = '0;
    cx        = in_x - XW'(1);
    cy        = in_y - YW'(1);
    rd_idx    = AW'(in_x);
    accept    = in_valid && in_ready;
    case (state)
      IDLE: ;
      RUN: begin
        if (accept) begin
          shift   = 1'b1;
          emit    = (in_x != '0) && (in_y != '0);
          col_top = (in_y <= YW'(1)) ? '0 : lb1[rd_idx];
          col_mid = lb0[rd_idx];
          col_bot = pixel_in;
          x_nxt   = in_x + XW'(1);
          if (in_x == XW'(IMG_W - 1)) state_nxt = EOL;
        end
      end
      EOL: begin
        shift     = 1'b1;
        emit      = (in_y != '0);
        cx        = XW'(IMG_W - 1);
        x_nxt     = '0;
        y_nxt     = in_y + YW'(1);
        state_nxt = (in_y == YW'(IMG_H - 1)) ? FLUSH : RUN;
      end
      FLUSH: begin
        shift = 1'b1;
        emit  = (in_x != '0);
        x_nxt = in_x + XW'(1);
        if (in_x == XW'(IMG_W)) begin
          last_win  = 1'b1;
          state_nxt = IDLE;
          x_nxt     = '0;
          y_nxt     = '0;
        end else begin
          col_top = lb1[rd_idx];
          col_mid = lb0[rd_idx];
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (frame_start) begin
      state_nxt = RUN;
      x_nxt     = '0;
      y_nxt     = '0;
      shift     = 1'b0;
      emit      = 1'b0;
      last_win  = 1'b0;
    end
    lb_wr = shift && (state == RUN);
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      taps_nxt[r][0] = taps[r][1];
      taps_nxt[r][1] = taps[r][2];
    end
    taps_nxt[0][2] = col_top;
    taps_nxt[1][2] = col_mid;
    taps_nxt[2][2] = col_bot;
  end

`ifdef WIN3_REPLICATE_EDGE_EN
  logic [1:0] rs, cs;

  // Redirect out-of-image taps to the centre row/column, which holds the nearest edge pixel
  always_comb begin
    win_nxt = taps_nxt;
    rs      = '0;
    cs      = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        rs = 2'(r);
        cs = 2'(c);
        if (r == 0 && cy == '0) rs = 2'd1;
        if (r == 2 && cy == YW'(IMG_H - 1)) rs = 2'd1;
        if (c == 0 && cx == '0) cs = 2'd1;
        if (c == 2 && cx == XW'(IMG_W - 1)) cs = 2'd1;
        win_nxt[r][c] = taps_nxt[rs][cs];
      end
    end
  end
`else
  always_comb begin
    win_nxt = taps_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      in_x       <= '0;
      in_y       <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      taps       <= '0;
      window     <= '0;
      out_addr   <= '0;
    end else begin
      in_x       <= x_nxt;
      in_y       <= y_nxt;
      in_ready   <= (state_nxt == RUN);
      out_valid  <= emit;
      frame_done <= last_win;
      if (shift) taps <= taps_nxt;
      if (emit) begin
        window   <= win_nxt;
        out_addr <= {cy, cx};
      end
    end
  end

  // Read-before-write: lb1 takes the line lb0 held before this write
  always_ff @(posedge clk) begin
    if (lb_wr) begin
      lb0[rd_idx] <= pixel_in;
      lb1[rd_idx] <= lb0[rd_idx];
    end
  end

endmodule

// File: tb/tb_window3x3_linebuf_rgb888.sv
// Bench for window3x3_linebuf_rgb888: random stimulus against a per-frame image model,
// plus literal checks of selected windows.
module tb_window3x3_linebuf_rgb888;
  localparam int W = 8;
  localparam int H = 4;
  localparam logic [16:0] LAST_ADDR = {8'(H - 1), 9'(W - 1)};

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_start;
  logic         in_valid;
  logic         in_ready;
  logic [23:0]  pixel_in;
  logic         out_valid;
  logic [215:0] window;
  logic [16:0]  out_addr;
  logic         frame_done;

  window3x3_linebuf_rgb888 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .in_ready(in_ready), .pixel_in(pixel_in), .out_valid(out_valid),
    .window(window), .out_addr(out_addr), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [215:0] win;
    logic [16:0]  addr;
  } exp_t;

  exp_t         exp_q[$];
  logic [23:0]  img [H][W];
  logic [215:0] cap [W*H];
  int checks = 0;
  int errors = 0;
  int cyc = 0, first_acc = -1, rdy_low = 0, fd_count = 0, emitted = 0;
  bit in_frame = 0, done_seen = 0, gapless = 0;
  logic [16:0] fd_addr = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected window straight from the image: tap (r,c) is pixel (cx+c-1, cy+r-1)
  function automatic logic [215:0] model_win(input int cx, input int cy);
    logic [215:0] w;
    int px, py;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        px = cx + c - 1;
        py = cy + r - 1;
`ifdef WIN3_REPLICATE_EDGE_EN
        if (px < 0) px = 0;
        if (px > W - 1) px = W - 1;
        if (py < 0) py = 0;
        if (py > H - 1) py = H - 1;
        w[215 - 24*(r*3 + c) -: 24] = img[py][px];
`else
        if (px >= 0 && px < W && py >= 0 && py < H)
          w[215 - 24*(r*3 + c) -: 24] = img[py][px];
`endif
      end
    end
    return w;
  endfunction

  function automatic logic [23:0] tap(input int idx, input int r, input int c);
    logic [215:0] w;
    w = cap[idx];
    return w[215 - 24*(r*3 + c) -: 24];
  endfunction

  task automatic fill_img(input int kind);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (kind)
          0:       img[y][x] = 24'h102030;
          1:       img[y][x] = {8'h00, 8'(y), 8'(x)};
          default: img[y][x] = 24'($urandom);
        endcase
  endtask

  task automatic start_frame(input bit gl);
    exp_t e;
    exp_q.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        e.win  = model_win(x, y);
        e.addr = {8'(y), 9'(x)};
        exp_q.push_back(e);
      end
    for (int i = 0; i < W*H; i++) cap[i] = '1;
    gapless     = gl;
    frame_start = 1'b1;
    in_valid    = 1'b0;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic feed(input int gap_pct, input int stop_after);
    int n, budget;
    bit acc, v, rdy;
    n = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (n < stop_after) begin
          acc = 0;
          budget = 0;
          while (!acc && budget < 64) begin
            v = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            pixel_in = v ? img[y][x] : 24'($urandom);
            rdy = in_ready;
            @(posedge clk); #1;
            acc = v && rdy;
            budget++;
          end
          if (!acc) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: pixel (%0d,%0d) not accepted within 64 cycles", x, y);
          end
          n++;
        end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while (!done_seen && b < 100) begin
      @(posedge clk); #1;
      b++;
    end
    chk("frame_done_seen", 256'(done_seen), 256'(1));
    @(posedge clk); #1;
    chk("windows_left", 256'(exp_q.size()), 256'(0));
    chk("frame_done_count", 256'(fd_count), 256'(1));
    chk("frame_done_addr", 256'(fd_addr), 256'(LAST_ADDR));
  endtask

  // Compare process: every sampled output cycle is checked against the expected queue
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      if (frame_start) begin
        in_frame = 1; first_acc = -1; rdy_low = 0; fd_count = 0; done_seen = 0; emitted = 0;
      end else if (in_frame) begin
        if (first_acc < 0 && in_valid && in_ready) first_acc = cyc;
        if (!frame_done && !in_ready) rdy_low++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: addr %0h with no window pending", out_addr);
        end else begin
          e = exp_q.pop_front();
          emitted++;
          chk("out_addr", 256'(out_addr), 256'(e.addr));
          chk($sformatf("window_%0d_%0d", e.addr[16:9], e.addr[8:0]), 256'(window), 256'(e.win));
          chk("frame_done_flag", 256'(frame_done), 256'(e.addr == LAST_ADDR));
          if (out_addr[8:0] < 9'(W) && out_addr[16:9] < 8'(H))
            cap[int'(out_addr[16:9])*W + int'(out_addr[8:0])] = window;
        end
        if (frame_done) begin
          fd_count++;
          done_seen = 1;
          fd_addr = out_addr;
          chk("ready_low_cycles", 256'(rdy_low), 256'(H + W + 1));
          if (gapless) chk("frame_duration", 256'(cyc - first_acc), 256'(H*(W+1) + (W+1)));
          in_frame = 0;
        end
      end else if (frame_done) begin
        checks++;
        errors++;
        $display("FAIL stray_frame_done: frame_done without out_valid");
      end
    end
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; in_valid = 1'b0; pixel_in = '0;
    repeat (3) begin
      @(posedge clk); #1;
      frame_start = 1'($urandom_range(1));
      in_valid    = 1'($urandom_range(1));
      pixel_in    = 24'($urandom);
    end
    @(negedge clk);
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_window", 256'(window), 256'(0));
    chk("rst_out_addr", 256'(out_addr), 256'(0));
    chk("rst_frame_done", 256'(frame_done), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0; frame_start = 1'b0; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_in_ready", 256'(in_ready), 256'(0));
      chk("idle_out_valid", 256'(out_valid), 256'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Constant frame, gapless
    fill_img(0); start_frame(1); feed(0, W*H); wait_done();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
`ifdef WIN3_REPLICATE_EDGE_EN
        chk($sformatf("const_c00_p%0d%0d", r, c), 256'(tap(0, r, c)), 256'(24'h102030));
`else
        chk($sformatf("const_c00_p%0d%0d", r, c), 256'(tap(0, r, c)),
            (r >= 1 && c >= 1) ? 256'(24'h102030) : 256'(0));
`endif
        chk($sformatf("const_c31_p%0d%0d", r, c), 256'(tap(1*W + 3, r, c)), 256'(24'h102030));
      end

    // Ramp frame, gapless
    fill_img(1); start_frame(1); feed(0, W*H); wait_done();
    chk("ramp_c32_p00", 256'(tap(2*W + 3, 0, 0)), 256'(24'h000102));
    chk("ramp_c32_p11", 256'(tap(2*W + 3, 1, 1)), 256'(24'h000203));
    chk("ramp_c32_p22", 256'(tap(2*W + 3, 2, 2)), 256'(24'h000304));
`ifdef WIN3_REPLICATE_EDGE_EN
    chk("rep_c00_p00", 256'(tap(0, 0, 0)), 256'(24'h000000));
    chk("rep_c00_p01", 256'(tap(0, 0, 1)), 256'(24'h000000));
    chk("rep_c00_p10", 256'(tap(0, 1, 0)), 256'(24'h000000));
    chk("rep_c00_p11", 256'(tap(0, 1, 1)), 256'(24'h000000));
    chk("rep_c00_p02", 256'(tap(0, 0, 2)), 256'(24'h000001));
    chk("rep_c00_p12", 256'(tap(0, 1, 2)), 256'(24'h000001));
    chk("rep_c00_p20", 256'(tap(0, 2, 0)), 256'(24'h000100));
    chk("rep_c00_p21", 256'(tap(0, 2, 1)), 256'(24'h000100));
    chk("rep_c00_p22", 256'(tap(0, 2, 2)), 256'(24'h000101));
    chk("rep_c73_p22", 256'(tap(3*W + 7, 2, 2)), 256'(24'h000307));
`else
    chk("ramp_c73_p02", 256'(tap(3*W + 7, 0, 2)), 256'(0));
    chk("ramp_c73_p12", 256'(tap(3*W + 7, 1, 2)), 256'(0));
    chk("ramp_c73_p22", 256'(tap(3*W + 7, 2, 2)), 256'(0));
    chk("ramp_c73_p20", 256'(tap(3*W + 7, 2, 0)), 256'(0));
    chk("ramp_c73_p21", 256'(tap(3*W + 7, 2, 1)), 256'(0));
`endif

    // Ramp frame with ~40% input gaps
    fill_img(1); start_frame(0); feed(40, W*H); wait_done();

    // Abort after 19 accepted beats of a random frame, then a fresh random frame
    fill_img(2); start_frame(0); feed(30, 19);
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_emitted", 256'(emitted), 256'(10));
    chk("abort_no_done", 256'(fd_count), 256'(0));
    fill_img(2); start_frame(1); feed(0, W*H); wait_done();
`ifndef WIN3_REPLICATE_EDGE_EN
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("abort_c00_top%0d", c), 256'(tap(0, 0, c)), 256'(0));
      chk($sformatf("abort_c30_top%0d", c), 256'(tap(3, 0, c)), 256'(0));
    end
`endif

    // Back-to-back random frame with gaps
    fill_img(2); start_frame(0); feed(25, W*H); wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
